digital_lock_4bit: RTL and testbench

- Pushbutton-driven 4-bit combination lock: the user sets code_in and presses enter; a matching code unlocks, wrong codes are counted.
- Reaching MAX_ATTEMPTS consecutive wrong entries forces a lockout; only admin_reset or reset clears it.
- Leaf block driving front-panel LEDs directly.

---
 rtl/digital_lock_4bit_pkg.sv | 30 +++
 rtl/digital_lock_4bit_edge_detect_rise.sv | 27 ++
 rtl/digital_lock_4bit.sv | 90 +++++++++
 tb/tb_digital_lock_4bit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/digital_lock_4bit_pkg.sv
// Shared definitions for the 4-bit combination lock.
// Contents:
//   lock_state_t         - lock FSM states (LOCKED, UNLOCKED, LOCKOUT)
//   DEFAULT_SECRET_CODE  - default unlock code
//   DEFAULT_MAX_ATTEMPTS - default consecutive wrong entries before lockout
//   count_to_therm()     - wrong-attempt count to 3-bit LED thermometer
package digital_lock_4bit_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } lock_state_t;

  localparam logic [3:0]  DEFAULT_SECRET_CODE  = 4'b1010;
  localparam int unsigned DEFAULT_MAX_ATTEMPTS = 3;

  // 0 -> 000, 1 -> 001, 2 -> 011, 3 -> 111
  function automatic logic [2:0] count_to_therm(input logic [1:0] cnt);
    logic [2:0] therm;
    case (cnt)
      2'd0:    therm = 3'b000;
      2'd1:    therm = 3'b001;
      2'd2:    therm = 3'b011;
      default: therm = 3'b111;
    endcase
    return therm;
  endfunction

endpackage

// File: rtl/digital_lock_4bit_edge_detect_rise.sv
// Rising-edge detector for a level input that is already synchronous to clk.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset (clears the delayed copy)
//   i_sig  - level input (pushbutton level)
//   o_rise - high for the one cycle where i_sig is high and was low last cycle
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= i_sig;
    end
  end

  // A held level yields exactly one pulse: only the first cycle sees r_sig_q low.
  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/digital_lock_4bit.sv
// Pushbutton-driven 4-bit combination lock driving front-panel LEDs.
// A press (rising edge of enter) with code_in == SECRET_CODE unlocks and
// clears the wrong-attempt count; a wrong code relocks and counts. Reaching
// MAX_ATTEMPTS consecutive wrong codes enters LOCKOUT, which ignores presses
// until admin_reset or reset.
// Ports:
//   clk         - system clock, all state changes on rising edge
//   reset       - asynchronous active-high reset
//   admin_reset - synchronous active-high; back to LOCKED with count 0
//   enter       - pushbutton level, synchronous to clk
//   code_in     - 4-bit code, examined only in the press cycle
//   unlock_led  - high while UNLOCKED
//   lockout_led - high while LOCKOUT
//   attempt_led - thermometer of the wrong-attempt count
module digital_lock_4bit
  import digital_lock_4bit_pkg::*;
#(
  parameter logic [3:0]  SECRET_CODE  = DEFAULT_SECRET_CODE,
  parameter int unsigned MAX_ATTEMPTS = DEFAULT_MAX_ATTEMPTS  // legal 1..3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       admin_reset,
  input  logic       enter,
  input  logic [3:0] code_in,
  output logic       unlock_led,
  output logic       lockout_led,
  output logic [2:0] attempt_led
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_ATTEMPTS);

  lock_state_t r_state;
  logic [1:0]  r_count;

  logic        w_press;
  lock_state_t w_next_state;
  logic [1:0]  w_next_count;
  logic [2:0]  w_count_inc;

  edge_detect_rise u_enter_edge (
    .clk    (clk),
    .rst    (reset),
    .i_sig  (enter),
    .o_rise (w_press)
  );

  // One bit wider than the count so the lockout compare cannot wrap.
  assign w_count_inc = {1'b0, r_count} + 3'd1;

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    if (admin_reset) begin
      // Takes precedence over a press arriving in the same cycle.
      w_next_state = ST_LOCKED;
      w_next_count = 2'd0;
    end else if (w_press && (r_state != ST_LOCKOUT)) begin
      if (code_in == SECRET_CODE) begin
        w_next_state = ST_UNLOCKED;
        w_next_count = 2'd0;
      end else if (w_count_inc >= MAX_CNT) begin
        w_next_state = ST_LOCKOUT;
        w_next_count = MAX_CNT[1:0];
      end else begin
        w_next_state = ST_LOCKED;
        w_next_count = w_count_inc[1:0];
      end
    end
  end

  // LEDs are decoded from the next state/count so they register on the
  // same edge that samples the press or admin_reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_LOCKED;
      r_count     <= 2'd0;
      unlock_led  <= 1'b0;
      lockout_led <= 1'b0;
      attempt_led <= 3'b000;
    end else begin
      r_state     <= w_next_state;
      r_count     <= w_next_count;
      unlock_led  <= (w_next_state == ST_UNLOCKED);
      lockout_led <= (w_next_state == ST_LOCKOUT);
      attempt_led <= count_to_therm(w_next_count);
    end
  end

endmodule

// File: tb/tb_digital_lock_4bit.sv
module tb_digital_lock_4bit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       admin_reset = 1'b0;
  logic       enter = 1'b0;
  logic [3:0] code_in = 4'b0000;
  logic       unlock_led;
  logic       lockout_led;
  logic [2:0] attempt_led;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  digital_lock_4bit dut (
    .clk         (clk),
    .reset       (reset),
    .admin_reset (admin_reset),
    .enter       (enter),
    .code_in     (code_in),
    .unlock_led  (unlock_led),
    .lockout_led (lockout_led),
    .attempt_led (attempt_led)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = locked, 1 = unlocked, 2 = lockout;
  // wrong is the number of consecutive wrong entries.
  int mode  = 0;
  int wrong = 0;
  bit prev_enter = 1'b0;
  bit m_press;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mode = 0;
      wrong = 0;
      prev_enter = 1'b0;
    end else begin
      m_press = enter && !prev_enter;
      prev_enter = enter;
      if (admin_reset) begin
        mode = 0;
        wrong = 0;
      end else if (m_press && mode != 2) begin
        if (code_in == 4'hA) begin
          mode = 1;
          wrong = 0;
        end else begin
          wrong = wrong + 1;
          if (wrong >= 3) begin
            mode = 2;
            wrong = 3;
          end else begin
            mode = 0;
          end
        end
      end
    end
  end

  function automatic logic [4:0] model_out();
    logic [2:0] att;
    att = 3'((1 << wrong) - 1);
    return {mode == 1, mode == 2, att};
  endfunction

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if ({unlock_led, lockout_led, attempt_led} !== model_out()) begin
        failures++;
        $display("FAIL model_cmp t=%0t got u/l/a=%b required=%b", $time,
                 {unlock_led, lockout_led, attempt_led}, model_out());
      end
    end
  end

  task automatic chk(input string name, input logic [4:0] exp);
    checks++;
    if ({unlock_led, lockout_led, attempt_led} !== exp) begin
      failures++;
      $display("FAIL %s got u/l/a=%b required=%b", name,
               {unlock_led, lockout_led, attempt_led}, exp);
    end
  endtask

  // Press then release; returns at the negedge after the sampling edge.
  task automatic press_code(input logic [3:0] c);
    @(negedge clk);
    code_in = c;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_state", 5'b00_000);

    press_code(4'b0001);
    chk("wrong1", 5'b00_001);
    press_code(4'b0010);
    chk("wrong2", 5'b00_011);
    press_code(4'b1010);
    chk("unlock", 5'b10_000);

    press_code(4'b0100);
    chk("relock_wrong1", 5'b00_001);
    press_code(4'b0101);
    chk("relock_wrong2", 5'b00_011);
    press_code(4'b0110);
    chk("lockout", 5'b01_111);

    press_code(4'b1010);
    chk("lockout_ignores", 5'b01_111);

    @(negedge clk);
    admin_reset = 1'b1;
    @(negedge clk);
    admin_reset = 1'b0;
    chk("admin_clear", 5'b00_000);
    press_code(4'b1010);
    chk("unlock_after_admin", 5'b10_000);

    // Held button: one press only.
    @(negedge clk);
    code_in = 4'b0011;
    enter = 1'b1;
    repeat (5) @(negedge clk);
    enter = 1'b0;
    chk("held_single_press", 5'b00_001);

    // code_in changes without a press do nothing.
    code_in = 4'b1010;
    repeat (3) @(negedge clk);
    chk("code_no_press", 5'b00_001);

    press_code(4'b1010);
    chk("unlock_before_rst", 5'b10_000);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1 chk("async_reset", 5'b00_000);
    #1 reset = 1'b0;

    // admin_reset wins over a wrong-code press in the same cycle.
    @(negedge clk);
    admin_reset = 1'b1;
    enter = 1'b1;
    code_in = 4'b0111;
    @(negedge clk);
    admin_reset = 1'b0;
    enter = 1'b0;
    chk("admin_beats_press", 5'b00_000);

    press_code(4'b1111);
    chk("wrong_after_admin", 5'b00_001);

    repeat (2) @(negedge clk);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
